bcd_entry_accum: RTL and testbench

Sequential, parametrised successor to the calculator's combinational BCD key handler. Accumulates decimal key presses into a DIGITS-digit BCD entry register with backspace, clear and overflow rejection. Converts the entry to a saturating BIN_W-bit binary operand through a multi-cycle MSD-first multiply-by-10 datapath with a start/busy/done handshake. Sits between the keypad decoder and the ALU operand registers.

---
 rtl/calc_pkg.sv | 13 +
 rtl/bcd_mac10.sv | 21 ++
 rtl/bcd_entry_accum.sv | 139 +++++++++++++
 tb/tb_bcd_entry_accum.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types for the calculator operand path: BCD digit type and the
// conversion FSM state encoding.
package calc_pkg;
  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } calc_state_t;
endpackage

// File: rtl/bcd_mac10.sv
// One step of decimal-to-binary conversion: acc*10 + digit, clamped to the
// largest BIN_W-bit value with a flag when the clamp engages.
module bcd_mac10 #(
  parameter int BIN_W = 8
) (
  input  logic [BIN_W-1:0] i_acc,
  input  logic [3:0]       i_digit,
  output logic [BIN_W-1:0] o_result,
  output logic             o_clamp
);
  localparam logic [BIN_W+3:0] MAX_VAL = {4'd0, {BIN_W{1'b1}}};

  logic [BIN_W+3:0] w_acc_ext;
  logic [BIN_W+3:0] w_sum;

  // Four guard bits hold (2^BIN_W-1)*10+9 without wrapping.
  assign w_acc_ext = {4'd0, i_acc};
  assign w_sum     = (w_acc_ext << 3) + (w_acc_ext << 1) + {{BIN_W{1'b0}}, i_digit};
  assign o_clamp   = (w_sum > MAX_VAL);
  assign o_result  = o_clamp ? {BIN_W{1'b1}} : w_sum[BIN_W-1:0];
endmodule

// File: rtl/bcd_entry_accum.sv
// Keypad BCD entry register with backspace/clear, plus a multi-cycle
// MSD-first conversion of the entry into a saturating binary operand.
module bcd_entry_accum
  import calc_pkg::*;
#(
  parameter  int DIGITS = 3,
  parameter  int BIN_W  = 8,
  localparam int NW     = $clog2(DIGITS + 1),
  localparam int IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_valid,
  input  logic [3:0]            key_digit,
  input  logic                  key_bksp,
  input  logic                  key_clr,
  input  logic                  conv_start,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [NW-1:0]         ndigits,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  sat,
  output logic                  key_rej
);
  logic [4*DIGITS-1:0] r_bcd;
  logic [NW-1:0]       r_nd;
  calc_state_t         r_state;
  logic [IW-1:0]       r_idx;
  logic [BIN_W-1:0]    r_acc;
  logic                r_acc_sat;
  logic                r_done;
  logic [BIN_W-1:0]    r_bin;
  logic                r_sat;
  logic                r_rej;

  bcd_digit_t          w_digits [DIGITS];
  bcd_digit_t          w_digit_sel;
  logic [BIN_W-1:0]    w_mac;
  logic                w_clamp;
  logic                w_busy;
  logic                w_final_sat;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign w_digits[gi] = r_bcd[4*gi +: 4];
    end
  endgenerate

  // Keys are locked out during CONV, so the live entry register doubles as
  // the conversion snapshot; key_clr aborts the conversion anyway.
  assign w_digit_sel = w_digits[r_idx];
  assign w_busy      = (r_state == CONV);
  assign w_final_sat = r_acc_sat | w_clamp;

  bcd_mac10 #(.BIN_W(BIN_W)) u_mac (
    .i_acc    (r_acc),
    .i_digit  (w_digit_sel),
    .o_result (w_mac),
    .o_clamp  (w_clamp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bcd     <= '0;
      r_nd      <= '0;
      r_state   <= IDLE;
      r_idx     <= '0;
      r_acc     <= '0;
      r_acc_sat <= 1'b0;
      r_done    <= 1'b0;
      r_bin     <= '0;
      r_sat     <= 1'b0;
      r_rej     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_rej  <= 1'b0;
      if (key_clr) begin
        r_bcd   <= '0;
        r_nd    <= '0;
        r_state <= IDLE;
      end else begin
        case (r_state)
          CONV: begin
            r_acc     <= w_mac;
            r_acc_sat <= w_final_sat;
            if (r_idx == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_bin   <= w_mac;
              r_sat   <= w_final_sat;
            end else begin
              r_idx <= r_idx - IW'(1);
            end
          end
          DONE:    r_state <= IDLE;
          default: r_state <= IDLE;
        endcase

        // Command arbitration; a later assignment to r_state wins over the
        // DONE->IDLE step above, giving back-to-back conversions.
        if (conv_start) begin
          if (w_busy) begin
            r_rej <= 1'b1;
          end else begin
            r_state   <= CONV;
            r_acc     <= '0;
            r_acc_sat <= 1'b0;
            r_idx     <= IW'(DIGITS - 1);
          end
        end else if (key_bksp) begin
          if (w_busy || (r_nd == '0)) begin
            r_rej <= 1'b1;
          end else begin
            r_bcd <= r_bcd >> 4;
            r_nd  <= r_nd - NW'(1);
          end
        end else if (key_valid) begin
          if (w_busy || (key_digit > BCD_MAX_DIGIT) || (r_nd == NW'(DIGITS))) begin
            r_rej <= 1'b1;
          end else begin
            r_bcd <= (r_bcd << 4) | (4*DIGITS)'(key_digit);
            if (!((r_nd == '0) && (key_digit == 4'd0))) begin
              r_nd <= r_nd + NW'(1);
            end
          end
        end
      end
    end
  end

  assign bcd_out = r_bcd;
  assign ndigits = r_nd;
  assign busy    = w_busy;
  assign done    = r_done;
  assign bin_out = r_bin;
  assign sat     = r_sat;
  assign key_rej = r_rej;
endmodule

// File: tb/tb_bcd_entry_accum.sv
// Directed plus random stimulus for bcd_entry_accum, checked every cycle
// against a decimal-value model of the entry and conversion.
module tb_bcd_entry_accum;
  localparam int DIGITS = 3;
  localparam int BIN_W  = 8;
  localparam int MAXV   = (1 << BIN_W) - 1;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                key_valid = 1'b1;
  logic [3:0]          key_digit = 4'd5;
  logic                key_bksp = 1'b1;
  logic                key_clr = 1'b1;
  logic                conv_start = 1'b1;
  logic [4*DIGITS-1:0] bcd_out;
  logic [1:0]          ndigits;
  logic                busy;
  logic                done;
  logic [BIN_W-1:0]    bin_out;
  logic                sat;
  logic                key_rej;

  int n_checks = 0;
  int n_err    = 0;

  // Model state: entry as a plain decimal number.
  int m_val, m_nd, m_cnt, m_snap, m_bin, m_sat, m_done, m_rej;

  bcd_entry_accum #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_digit(key_digit),
    .key_bksp(key_bksp), .key_clr(key_clr), .conv_start(conv_start),
    .bcd_out(bcd_out), .ndigits(ndigits), .busy(busy), .done(done),
    .bin_out(bin_out), .sat(sat), .key_rej(key_rej)
  );

  always #5 clk = ~clk;

  function automatic int to_bcd(input int v);
    int r = 0;
    for (int i = 0; i < DIGITS; i++) begin
      r |= (v % 10) << (4 * i);
      v /= 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_val = 0; m_nd = 0; m_cnt = 0; m_snap = 0;
    m_bin = 0; m_sat = 0; m_done = 0; m_rej = 0;
  endtask

  task automatic model_step(input bit kv, input int kd, input bit kb, input bit kc, input bit cs);
    bit was_busy;
    was_busy = (m_cnt > 0);
    m_done = 0;
    m_rej  = 0;
    if (kc) begin
      m_val = 0; m_nd = 0; m_cnt = 0;
    end else begin
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_done = 1;
          m_bin  = (m_snap > MAXV) ? MAXV : m_snap;
          m_sat  = (m_snap > MAXV) ? 1 : 0;
        end
      end
      if (cs) begin
        if (was_busy) m_rej = 1;
        else begin m_snap = m_val; m_cnt = DIGITS; end
      end else if (kb) begin
        if (was_busy || m_nd == 0) m_rej = 1;
        else begin m_val = m_val / 10; m_nd--; end
      end else if (kv) begin
        if (was_busy || kd > 9 || m_nd == DIGITS) m_rej = 1;
        else if (!(m_nd == 0 && kd == 0)) begin m_val = m_val * 10 + kd; m_nd++; end
      end
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".bcd_out"}, int'(bcd_out), to_bcd(m_val));
    chk({ctx, ".ndigits"}, int'(ndigits), m_nd);
    chk({ctx, ".busy"},    int'(busy),    (m_cnt > 0) ? 1 : 0);
    chk({ctx, ".done"},    int'(done),    m_done);
    chk({ctx, ".bin_out"}, int'(bin_out), m_bin);
    chk({ctx, ".sat"},     int'(sat),     m_sat);
    chk({ctx, ".key_rej"}, int'(key_rej), m_rej);
  endtask

  task automatic step(input string ctx, input bit kv, input int kd, input bit kb, input bit kc, input bit cs);
    key_valid = kv; key_digit = 4'(kd); key_bksp = kb; key_clr = kc; conv_start = cs;
    model_step(kv, kd, kb, kc, cs);
    @(posedge clk); #1;
    key_valid = 0; key_bksp = 0; key_clr = 0; conv_start = 0;
    check_all(ctx);
    $display("step %-10s kv=%0d kd=%0d bk=%0d clr=%0d cs=%0d -> bcd=%03h nd=%0d busy=%0d done=%0d bin=%0d sat=%0d rej=%0d",
             ctx, kv, kd, kb, kc, cs, bcd_out, ndigits, busy, done, bin_out, sat, key_rej);
  endtask

  task automatic key(input string ctx, input int d);   step(ctx, 1, d, 0, 0, 0); endtask
  task automatic idle(input string ctx);                step(ctx, 0, 0, 0, 0, 0); endtask
  task automatic conv(input string ctx);                step(ctx, 0, 0, 0, 0, 1); endtask
  task automatic clr(input string ctx);                 step(ctx, 0, 0, 0, 1, 0); endtask
  task automatic bksp(input string ctx);                step(ctx, 0, 0, 1, 0, 0); endtask

  task automatic enter3(input string ctx, input int a, input int b, input int c);
    clr(ctx); key(ctx, a); key(ctx, b); key(ctx, c);
  endtask

  initial begin
    // Reset with every strobe asserted
    @(posedge clk); @(posedge clk); #1;
    rst = 0; key_valid = 0; key_bksp = 0; key_clr = 0; conv_start = 0; key_digit = 0;
    model_reset();
    check_all("reset");

    // Digit entry, leading zero, overflow and illegal digit
    key("lead0", 0);
    chk("lead0.nd_zero", int'(ndigits), 0);
    key("k1", 1); key("k2", 2); key("k3", 3);
    chk("entry123", int'(bcd_out), 'h123);
    key("k4_over", 4);
    key("kA_bad", 10);

    // Conversion of 123 with a key press while busy
    conv("conv123");
    key("key_busy", 7);
    idle("wait"); idle("wait");
    chk("bin123", int'(bin_out), 123);
    idle("after");

    // Saturation boundaries
    enter3("e999", 9, 9, 9); conv("c999"); repeat (4) idle("w999");
    enter3("e255", 2, 5, 5); conv("c255"); repeat (4) idle("w255");
    enter3("e256", 2, 5, 6); conv("c256"); repeat (4) idle("w256");

    // Backspace sequence
    enter3("e123b", 1, 2, 3);
    bksp("bk1"); chk("bk1.val", int'(bcd_out), 'h012);
    bksp("bk2"); bksp("bk3"); bksp("bk4_rej");

    // conv_start and bksp together: bksp dropped silently
    enter3("e123c", 1, 2, 3);
    step("cs_bksp", 0, 0, 1, 0, 1);
    repeat (4) idle("wcb");

    // Abort with key_clr on the second busy cycle
    enter3("e456", 4, 5, 6);
    conv("cabort"); idle("busy2"); clr("abort");
    repeat (4) idle("wab");

    // Back-to-back conversion started in the done cycle
    enter3("e789", 7, 8, 9);
    conv("cb2b"); idle("b1"); idle("b2"); idle("b3_done");
    conv("c_in_done");
    repeat (4) idle("wb2b");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      bit kv, kb, kc, cs;
      int kd;
      kv = ($urandom_range(0, 1) == 0);
      kd = $urandom_range(0, 11);
      kb = ($urandom_range(0, 5) == 0);
      kc = ($urandom_range(0, 29) == 0);
      cs = ($urandom_range(0, 7) == 0);
      step("rand", kv, kd, kb, kc, cs);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
